div: RTL and testbench

- Sequential signed 32-bit divider for the multicycle datapath.
- It is the inverse counterpart of the Booth `mult` block and is driven by the control unit in the same way: operands come from `RegAOut` / `RegBOut`, and a one-cycle `DivCtrl` start pulse begins an operation.
- On completion it writes LO (quotient) and HI (remainder) and pulses `DivDone`.
- A zero divisor is flagged on `DivZero` so control can raise the exception.

---
 rtl/div.sv | 65 ++++++
 tb/tb_div.sv | 130 +++++++++++++
 2 files changed

// File: rtl/div.sv
// div: sequential signed restoring divider producing MIPS-style quotient (LO) and remainder (HI)
module div #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] RegAOut,
  input  logic [DATA_W-1:0] RegBOut,
  input  logic              DivCtrl,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO,
  output logic              DivDone,
  output logic              DivZero,
  output logic              DivBusy
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_n;
  logic              sa, sb, start, zero_req, last;
  logic [DATA_W-1:0] b_abs, r, q, rs;
  logic [DATA_W:0]   t;
  logic [CW-1:0]     cnt;
  assign start    = state == IDLE && DivCtrl && RegBOut != '0;
  assign zero_req = state == IDLE && DivCtrl && RegBOut == '0;
  assign last     = cnt == CW'(DATA_W - 1);
  assign DivBusy  = state != IDLE;
  // Next state plus the trial subtraction of the shifted remainder
  always_comb begin
    rs = {r[DATA_W-2:0], q[DATA_W-1]};
    t = {r, q[DATA_W-1]} - {1'b0, b_abs};
    state_n = start ? RUN : state == RUN ? (last ? FIX : RUN) : IDLE;
  end
  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else state <= state_n;
  end
  // Operand capture, one quotient bit per RUN cycle, sign fix-up and result pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      {sa, sb, b_abs, r, q, cnt} <= '0;
      {HI, LO, DivDone, DivZero} <= '0;
    end else begin
      DivDone <= state == FIX;
      DivZero <= zero_req;
      if (start) begin
        sa    <= RegAOut[DATA_W-1];
        sb    <= RegBOut[DATA_W-1];
        q     <= RegAOut[DATA_W-1] ? -RegAOut : RegAOut;
        b_abs <= RegBOut[DATA_W-1] ? -RegBOut : RegBOut;
        r     <= '0;
        cnt   <= '0;
      end
      if (state == RUN) begin
        r   <= t[DATA_W] ? rs : t[DATA_W-1:0];
        q   <= {q[DATA_W-2:0], ~t[DATA_W]};
        cnt <= cnt + 1'b1;
      end
      if (state == FIX) begin
        LO <= (sa ^ sb) ? -q : q;
        HI <= sa ? -r : r;
      end
    end
  end
endmodule

// File: tb/tb_div.sv
// tb_div: scoreboard bench for the signed sequential divider
module tb_div;
  logic        clk = 0, reset = 0, DivCtrl = 0;
  logic [31:0] RegAOut = 0, RegBOut = 0, HI, LO;
  logic        DivDone, DivZero, DivBusy;
  int          passed = 0, total = 0;
  typedef struct packed {logic [31:0] lo, hi;} exp_t;
  exp_t sbq[$];

  div #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .RegAOut(RegAOut), .RegBOut(RegBOut), .DivCtrl(DivCtrl),
    .HI(HI), .LO(LO), .DivDone(DivDone), .DivZero(DivZero), .DivBusy(DivBusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    longint la = longint'(signed'(a));
    longint lb = longint'(signed'(b));
    model.lo = 32'(la / lb);
    model.hi = 32'(la % lb);
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit push);
    @(negedge clk);
    RegAOut = a;
    RegBOut = b;
    DivCtrl = 1;
    if (push) sbq.push_back(model(a, b));
    @(negedge clk);
    DivCtrl = 0;
    RegAOut = $urandom;
    RegBOut = $urandom;
  endtask

  task automatic wait_done(input string tag, input int lat0);
    int   lat = lat0;
    bit   bad = 0;
    logic [31:0] hi0 = HI, lo0 = LO;
    exp_t e;
    while (!DivDone && lat < 60) begin
      if (!DivBusy || HI !== hi0 || LO !== lo0 || DivZero) bad = 1;
      @(negedge clk);
      lat++;
    end
    chk({tag, ":lat"}, lat, 33);
    chk({tag, ":busy_hold"}, {31'd0, bad}, 0);
    chk({tag, ":busy_end"}, {31'd0, DivBusy}, 0);
    chk({tag, ":sbq"}, sbq.size(), 1);
    if (DivDone && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, ":LO"}, LO, e.lo);
      chk({tag, ":HI"}, HI, e.hi);
    end
  endtask

  task automatic quiet(input string tag, input int n);
    int dn = 0;
    repeat (n) begin
      @(negedge clk);
      if (DivDone) dn++;
    end
    chk({tag, ":no_done"}, dn, 0);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input string tag);
    start_op(a, b, 1);
    wait_done(tag, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst:HI", HI, 0);
    chk("rst:LO", LO, 0);
    chk("rst:flags", {29'd0, DivDone, DivZero, DivBusy}, 0);
    reset = 1;
    run(42, 5, "42/5");
    chk("42/5:const", LO, 8);
    run(32'hFFFFFFF9, 2, "-7/2");
    chk("-7/2:const", {LO[3:0], HI[3:0]}, 8'hDF);
    run(7, 32'hFFFFFFFE, "7/-2");
    run(32'hFFFFFFF9, 32'hFFFFFFFE, "-7/-2");
    run(100, 7, "100/7");
    start_op(5, 0, 0);
    chk("dz:zero", {30'd0, DivZero, DivBusy}, 2);
    @(negedge clk);
    chk("dz:zero_clr", {31'd0, DivZero}, 0);
    quiet("dz", 40);
    chk("dz:HI", HI, 2);
    chk("dz:LO", LO, 14);
    chk("dz:busy", {31'd0, DivBusy}, 0);
    run(32'h80000000, 32'hFFFFFFFF, "ovf");
    chk("ovf:const", LO, 32'h80000000);
    run(32'h80000000, 1, "min/1");
    run(3, 10, "3/10");
    start_op(1000, 3, 1);
    repeat (9) @(negedge clk);
    RegAOut = 9;
    RegBOut = 9;
    DivCtrl = 1;
    @(negedge clk);
    DivCtrl = 0;
    wait_done("ign", 10);
    chk("ign:const", LO, 333);
    quiet("ign", 40);
    start_op(1000, 3, 0);
    repeat (14) @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1;
    chk("abort:HI", HI, 0);
    chk("abort:LO", LO, 0);
    chk("abort:busy", {31'd0, DivBusy}, 0);
    quiet("abort", 40);
    run(6, 4, "6/4");
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a = $urandom, b = $urandom >> $urandom_range(0, 31);
      if (b == 0) b = 1;
      run(a, b, "rand");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
